// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_OP_W = 2;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic op_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle, XLEN cycles.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            go,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dsor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;

  // The dividend is shifted out of the quotient register as quotient bits shift in.
  always_comb begin
    rem_sh = {rem_q, quot_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsor_q};
    rem_d  = diff[XLEN-1:0];
    quot_d = {quot_q[XLEN-2:0], 1'b1};
    if (diff[XLEN]) begin
      rem_d  = rem_sh[XLEN-1:0];
      quot_d = {quot_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (kill) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dsor_q <= divisor;
      cnt_q  <= CNT_W'(XLEN);
      run_q  <= 1'b1;
    end else if (run_q) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - CNT_W'(1);
      run_q  <= (cnt_q != CNT_W'(1));
    end
  end

  // Final step is in flight; quot/rem are valid from the next cycle on.
  assign done = run_q & (cnt_q == CNT_W'(1));
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit feeding the HI/LO write path, with start/valid handshake,
// stall request and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [XLEN-1:0]    src_a,
  input  logic [XLEN-1:0]    src_b,
  input  logic               flush,
  output logic               stall_req,
  output logic               busy,
  output logic               res_valid,
  output logic [XLEN-1:0]    hi_res,
  output logic [XLEN-1:0]    lo_res,
  output logic               div_by_zero
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             in_sgn;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             div_go, div_done;
  logic [XLEN-1:0]  div_quot, div_rem;
  logic [2*XLEN-1:0] prod;
  logic             neg_quot, neg_rem;

  assign in_sgn = op_is_signed(op);
  assign mag_a  = (in_sgn & src_a[XLEN-1]) ? (~src_a + XLEN'(1)) : src_a;
  assign mag_b  = (in_sgn & src_b[XLEN-1]) ? (~src_b + XLEN'(1)) : src_b;
  assign div_go = (state_q == ST_IDLE) & start & ~flush & op[1];

  // Low 2*XLEN bits of the product of sign/zero-extended operands.
  assign prod = {{XLEN{sgn_q & a_q[XLEN-1]}}, a_q} * {{XLEN{sgn_q & b_q[XLEN-1]}}, b_q};

  assign neg_quot = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_rem  = sgn_q & a_q[XLEN-1];

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .kill     (flush),
    .go       (div_go),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_d   = in_sgn;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = CNT_W'(MUL_LAT - 1);
          state_d = op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = prod;
          dbz_d        = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (b_q == '0) begin
          lo_d  = '1;
          hi_d  = a_q;
          dbz_d = 1'b1;
        end else begin
          lo_d  = neg_quot ? (~div_quot + XLEN'(1)) : div_quot;
          hi_d  = neg_rem ? (~div_rem + XLEN'(1)) : div_rem;
          dbz_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush aborts everything and leaves the visible results untouched.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_DONE) & ~flush;
  assign stall_req   = start & ~res_valid;
  assign hi_res      = hi_q;
  assign lo_res      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage. It generalises the single-cycle ALU HI/LO path to a configurable data width and a configurable multiply latency, with an explicit start/valid handshake, a stall request, and a flush. It feeds the HI/LO write path: its `hi_res`/`lo_res` are written under the stage's `w_hilo_ena`.

## Interface
- `XLEN`, default 32: operand and result width.
- `MUL_LAT`, default 2: number of multiply busy cycles, ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  operation request.
  - Level signal, held by the stage while `stall_req` is high.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  XLEN  multiplicand or dividend.
- `src_b`  in  XLEN  multiplier or divisor.
- `flush`  in  1  abort any operation; highest priority after `rst`.
- `stall_req`  out  1  combinational: `start & ~res_valid`.
- `busy`  out  1  state ≠ IDLE.
- `res_valid`  out  1  one-cycle result strobe.
- `hi_res`  out  XLEN  product high half, or remainder.
- `lo_res`  out  XLEN  product low half, or quotient.
- `div_by_zero`  out  1  qualifies `res_valid` for DIV/DIVU with `src_b == 0`.

## Operation
- **States:** IDLE, MUL, DIV, FIX, DONE.
- **IDLE:**
  - On `start & ~flush`, latch `op`, `src_a` and `src_b`.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
  - Operands are not re-sampled after this cycle.
- **MUL:**
  - Product is 2·XLEN wide.
  - Signed ops sign-extend both operands to XLEN+1 bits; unsigned ops zero-extend.
  - Stay MUL_LAT cycles (down-counter), then go to DONE. Implementation may pipeline the product across MUL_LAT registers.
- **DIV:**
  - Radix-2 restoring division on magnitudes: one quotient bit per cycle, XLEN cycles, then FIX.
  - Partial remainder is XLEN+1 bits.
  - Signed ops take the absolute value of each operand at latch time.
- **FIX:** apply sign correction.
  - Quotient is negated if sign(a)^sign(b).
  - Remainder is negated if sign(a).
  - Divide by zero (both DIV and DIVU) overrides the result: `lo_res` = all ones, `hi_res` = `src_a`, and `div_by_zero` is set.
  - DIV of most-negative by −1 gives `lo_res` = most-negative and `hi_res` = 0.
- **DONE:**
  - `hi_res`/`lo_res` were registered on entry.
  - Assert `res_valid` for exactly this cycle, then go to IDLE.
  - `start` is ignored in DONE.
- **Results:** `hi_res`/`lo_res` hold their values until the next DONE. They are unchanged by flush.
- **Stage rule:** the stage advances in the `res_valid` cycle. It keeps `start` high in the following IDLE cycle only when it is presenting a new operation.

## Timing
- Cycle 0 is the IDLE cycle in which `start` is accepted.
- **Multiply:** `res_valid` in cycle MUL_LAT+1 (cycle 3 at default).
- **Divide:** `res_valid` in cycle XLEN+2 (cycle 34 at default). Fixed latency, with no early-out.
- **`stall_req`:** high from cycle 0 through the cycle before `res_valid`, and low in the `res_valid` cycle.
- **Flush:**
  - In any state: next state is IDLE, with no `res_valid` for the aborted op.
  - Flush in DONE: `res_valid = (state==DONE) & ~flush`, so the strobe is suppressed; `hi_res`/`lo_res` may already hold the new values.
  - Flush in IDLE together with `start`: the operation is not accepted.
- **Reset values:** state IDLE; `busy`, `res_valid`, `div_by_zero`, `hi_res`, `lo_res` and all counters 0. Reset mid-operation discards it.
- **Back-to-back:** a new op is accepted the cycle after DONE, giving a minimum issue interval of MUL_LAT+2 cycles.

## Structure
- **`muldiv_pkg`:**
  - Op codes: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - State encoding.
  - `MD_OP_W` = 2.
- **`muldiv_div_core` sub-module:**
  - Iterative restoring divider, parametrised by XLEN.
  - Ports: `clk`, `rst`, `kill`, `go`, `dividend`, `divisor`, `quot`, `rem`, `done`.
  - Handles magnitudes only; sign handling stays in the top level.
- **Top level:** multiplier (product registers and latency counter), FSM, and output registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_res`=0xFFFFFFFE, `lo_res`=0x00000001; `res_valid` in cycle 3 only; `stall_req` high in cycles 0–2.
- MULT 0xFFFFFFFE × 3 → `hi_res`=0xFFFFFFFF, `lo_res`=0xFFFFFFFA.
- DIV 0xFFFFFFF9 / 2 → `lo_res`=0xFFFFFFFD, `hi_res`=0xFFFFFFFF; `res_valid` in cycle 34.
- DIVU 7 / 0 → `lo_res`=0xFFFFFFFF, `hi_res`=7, `div_by_zero`=1. DIV 0x80000000 / 0xFFFFFFFF → `lo_res`=0x80000000, `hi_res`=0, `div_by_zero`=0.
- **Flush scenario:**
  - Run DIVU 100/7 and flush in cycle 10: no `res_valid`, `busy`=0 next cycle, `hi_res`/`lo_res` keep their previous values.
  - Then MULTU 3×4: `lo_res`=12 three cycles after accept.
- **Reset scenario:**
  - Assert `rst` in cycle 5 of a DIV: all outputs 0 next cycle.
  - `start` held high through `rst` is accepted in the first IDLE cycle after `rst` falls.
